// File: rtl/forwarding_pkg.sv
// Shared definitions for the EX-stage forwarding muxes and the forwarding/hazard unit.
// Holds the select encoding, the register-number width and the pipeline slot record.
// Pure declarations: no logic, no latency.
package forwarding_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_ORIGINAL = 2'b00;  // register-file data
  localparam logic [1:0] FWD_MEM      = 2'b01;  // Write_Data_WB
  localparam logic [1:0] FWD_EX       = 2'b10;  // ALU_Result_MEM

  // Shadow of an in-flight instruction's destination; wr is only ever 1 for dest != 0.
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wr;
    logic             ld;
  } slot_t;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Priority compare of one source operand against the EX and MEM producer slots.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module fwd_select
  import forwarding_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  output logic [1:0]       sel
);

  // EX slot is checked first because it holds the youngest producer.
  always_comb begin
    sel = FWD_ORIGINAL;
    if (used && (src != '0) && ex_slot.wr && (ex_slot.dest == src)) begin
      sel = FWD_EX;
    end else if (used && (src != '0) && mem_slot.wr && (mem_slot.dest == src)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forward_A/B select generation (decided in ID, registered into EX) and load-use stall detection.
// Selects valid one edge after the consumer leaves ID; Stall_ID is combinational.
// Hold freezes all state; a stall or flush inserts a bubble into the EX slot.
module forwarding_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             Rs_Used_ID,
  input  logic             Rt_Used_ID,
  input  logic [REG_W-1:0] Write_Reg_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             Flush_ID,
  input  logic             Hold,
  output logic [1:0]       Forward_A,
  output logic [1:0]       Forward_B,
  output logic             Stall_ID,
  output logic [CNT_W-1:0] Stall_Count
);

  import forwarding_pkg::*;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             hazard;

  fwd_select u_sel_a (
    .src      (Rs_ID),
    .used     (Rs_Used_ID),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (sel_a)
  );

  fwd_select u_sel_b (
    .src      (Rt_ID),
    .used     (Rt_Used_ID),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (sel_b)
  );

  // Load in EX whose result the ID instruction needs; a killed ID instruction never waits.
  always_comb begin
    hazard = ex_q.wr && ex_q.ld &&
             ((Rs_Used_ID && (Rs_ID == ex_q.dest)) ||
              (Rt_Used_ID && (Rt_ID == ex_q.dest)));
    Stall_ID = hazard && !Flush_ID;
  end

  // Next-state: advance slots, register selects, count stalls; everything holds under Hold.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    if (!Hold) begin
      mem_d = '{dest: ex_q.dest, wr: ex_q.wr, ld: 1'b0};
      if (Stall_ID || Flush_ID) begin
        ex_d    = '0;
        fwd_a_d = FWD_ORIGINAL;
        fwd_b_d = FWD_ORIGINAL;
      end else begin
        ex_d    = '{dest: Write_Reg_ID,
                    wr:   RegWrite_ID && (Write_Reg_ID != '0),
                    ld:   MemRead_ID};
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
      end
      if (Stall_ID && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= FWD_ORIGINAL;
      fwd_b_q     <= FWD_ORIGINAL;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Forward_A   = fwd_a_q;
  assign Forward_B   = fwd_b_q;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control-side counterpart of the EX-stage forwarding muxes. Generates the registered Forward_A/Forward_B select codes the muxes consume, and detects load-use hazards.
- Sits between ID and EX. It shadows the destination registers of the instructions in EX and MEM internally, so selects are decided in ID and registered. They are valid from the first edge of the consuming instruction's EX cycle.
- Drives the stall/bubble controls for PC, IF/ID and ID/EX.

Parameters:
- REG_W, 5, register-number width
- CNT_W, 16, width of the saturating stall-event counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- Rs_ID  in  REG_W  rs field of the instruction in ID
- Rt_ID  in  REG_W  rt field of the instruction in ID
- Rs_Used_ID  in  1  instruction in ID reads rs
- Rt_Used_ID  in  1  instruction in ID reads rt (R-type, store, branch)
- Write_Reg_ID  in  REG_W  destination register selected in ID
- RegWrite_ID  in  1  instruction in ID writes the register file
- MemRead_ID  in  1  instruction in ID is a load
- Flush_ID  in  1  kill the instruction in ID (branch/jump taken)
- Hold  in  1  global pipeline freeze (memory wait)
- Forward_A  out  2  rs operand select for EX, registered
- Forward_B  out  2  rt operand select for EX, registered
- Stall_ID  out  1  combinational: hold PC and IF/ID, zero ID/EX control
- Stall_Count  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Select encoding (shared with the muxes):
  - 00 ORIGINAL: register-file data
  - 01 MEM_FORWARD: Write_Data_WB
  - 10 EX_FORWARD: ALU_Result_MEM
  - 11 is never driven.
- Reset state, asynchronous: EX slot and MEM slot empty; Forward_A=Forward_B=00; Stall_Count=0. Stall_ID is then 0.
- Internal slots:
  - EX slot: {dest, wr, ld}.
  - MEM slot: {dest, wr}.
  - "wr" is only ever stored as 1 when dest != 0. Register 0 is never forwarded.
- Hazard (combinational), true when EX.wr & EX.ld & ((Rs_Used_ID & Rs_ID==EX.dest) | (Rt_Used_ID & Rt_ID==EX.dest)).
- Stall_ID = hazard & ~Flush_ID. A killed instruction never waits.
- Select computation for X in {A: Rs, B: Rt}, checked in priority order:
  - used & src!=0 & EX.wr & EX.dest==src -> 10
  - else used & src!=0 & MEM.wr & MEM.dest==src -> 01
  - else 00
  - The EX slot has priority: it holds the youngest producer.
- WB-stage producers need no forwarding. The register file writes before it reads in the same cycle.
- Clock edge with Hold=1: all state, including outputs and the counter, holds. Stall_ID still reflects the hazard.
- Clock edge with Hold=0:
  - MEM slot <= {EX.dest, EX.wr}.
  - If Stall_ID or Flush_ID: EX slot <= empty (bubble) and Forward_A/B <= 00.
  - Otherwise: EX slot <= {Write_Reg_ID, RegWrite_ID & (Write_Reg_ID!=0), MemRead_ID}, and Forward_A/B <= computed selects.
  - If Stall_ID and Stall_Count not all ones: Stall_Count increments.
- Latency and cycle sequence:
  - A load-use pair costs exactly one stall cycle.
  - On the next cycle the load sits in the MEM slot, the hazard clears, and the consumer receives select 01.
- Simultaneous Flush_ID and hazard: flush wins, no stall, bubble inserted, counter unchanged.
- Reset asserted mid-stall: the state clears immediately and Stall_ID drops in the same cycle.

Decomposition:
- Package forwarding_pkg holds:
  - select constants FWD_ORIGINAL=2'b00, FWD_MEM=2'b01, FWD_EX=2'b10
  - REG_W
  - a slot struct {dest, wr, ld}
- The muxes and this unit both import it.
- One natural sub-module, fwd_select: the combinational priority compare, instantiated twice (A and B).

Test Plan:
1. ALU back-to-back: add $3 then sub reading $3 as rs -> Forward_A=10 in the sub's EX cycle, Forward_B=00, Stall_ID=0.
2. Distance-2 dependency: add $5, nop, then or reading $5 as rt -> Forward_B=01, Forward_A=00.
3. Both slots match: writer $7 in MEM, newer writer $7 in EX, consumer reads $7 as rs and rt -> both selects 10 (EX priority).
4. Load-use: lw $4, then add reading $4 as rt -> expect:
   - Stall_ID=1 for exactly one cycle, then a bubble with selects 00
   - next cycle Forward_B=01
   - Stall_Count 0->1
5. Register zero: writer to $0 followed by a reader of $0 -> selects 00, no stall.
6. Combined flush/hold/reset:
   - Flush_ID concurrent with a load-use hazard -> Stall_ID=0, Stall_Count unchanged.
   - Hold=1 for 3 cycles -> Forward_A/B and slots frozen.
   - reset asserted mid-stall -> outputs 00/0 without waiting for a clock edge.
